// File: rtl/partsub_pkg.sv
`default_nettype none
// ============================================================================
// partsub_pkg : shared types and constants for the serial partitioned subtractor
// Rev 1.0
// ============================================================================
package partsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } partsub_state_t;

    localparam int unsigned PARTSUB_WIDTH = 64;
    localparam int unsigned PARTSUB_SLICE = 8;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int unsigned partsub_cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_partsub_sub_slice.sv
`default_nettype none
// ============================================================================
// sub_slice : combinational SLICE-bit subtract slice, {bout, d} = a - b - bin
// Rev 1.0
// ============================================================================
module sub_slice #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] d_o,
    output logic             bout_o
);

    logic [SLICE:0] w_diff;

    // One extra bit captures the borrow as the sign of the widened difference.
    assign w_diff = {1'b0, a_i} - {1'b0, b_i} - {{SLICE{1'b0}}, bin_i};
    assign d_o    = w_diff[SLICE-1:0];
    assign bout_o = w_diff[SLICE];

endmodule
`default_nettype wire

// File: rtl/serial_partsub.sv
`default_nettype none
// ============================================================================
// serial_partsub : D = A - B - Bin, one SLICE-bit slice per clock, LSB first.
// Optional signed-overflow output Ovf when PARTSUB_OVF_EN is defined.
// Rev 1.0
// ============================================================================
module serial_partsub
    import partsub_pkg::*;
#(
    parameter int unsigned WIDTH = PARTSUB_WIDTH,
    parameter int unsigned SLICE = PARTSUB_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef PARTSUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = partsub_cnt_w(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0 || NSLICE < 2) begin : g_bad_params
        $error("serial_partsub: WIDTH must be a multiple of SLICE with at least two slices");
    end

    partsub_state_t   state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;

    logic [SLICE-1:0] w_a_slice, w_b_slice, w_slice_d;
    logic             w_slice_bout;
    logic             w_accept;

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept)     state_d = RUN;
            RUN:     if (k_q == LAST)  state_d = DONE;
            DONE:    if (out_ready)    state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (k_q == CW'(i)) begin
                w_a_slice = a_q[i*SLICE +: SLICE];
                w_b_slice = b_q[i*SLICE +: SLICE];
            end
        end
    end

    sub_slice #(.SLICE(SLICE)) u_slice (
        .a_i    (w_a_slice),
        .b_i    (w_b_slice),
        .bin_i  (borrow_q),
        .d_o    (w_slice_d),
        .bout_o (w_slice_bout)
    );

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                // Borrow-in seeds the chain register, so slice 0 sees it directly.
                if (w_accept) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    k_d      = '0;
                end
            end
            RUN: begin
                borrow_d = w_slice_bout;
                k_d      = (k_q == LAST) ? '0 : k_q + CW'(1);
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (k_q == CW'(i)) d_d[i*SLICE +: SLICE] = w_slice_d;
                end
                if (k_q == LAST) bout_d = w_slice_bout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            k_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

    assign D    = d_q;
    assign Bout = bout_q;

`ifdef PARTSUB_OVF_EN
    assign Ovf = out_valid && (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_q[WIDTH-1] != a_q[WIDTH-1]);
`else
    // Overflow detection is not built in this configuration.
`endif

endmodule
`default_nettype wire
